// File: rtl/mcpu_mem_arb.sv
`default_nettype none
//==============================================================================
// Module  : mcpu_mem_arb
// Brief   : Arbitrates two core data-memory ports onto one shared RAM/MMIO port.
//           Define MCPU_MEM_ARB_RR_EN for round-robin; default is port-0 priority.
// Rev     : 1.0  initial release
//==============================================================================
module mcpu_mem_arb #(
  parameter int ADDR_W   = 30,
  parameter int DATA_W   = 32,
  parameter int MMIO_BIT = 29,
  parameter int RAM_AW   = 14
) (
  input  logic                  clkrst_core_clk,
  input  logic                  clkrst_core_rst_n,
  input  logic [ADDR_W-1:0]     mem2dc_paddr0,
  input  logic [DATA_W/8-1:0]   mem2dc_write0,
  input  logic                  mem2dc_valid0,
  input  logic [DATA_W-1:0]     mem2dc_data_out0,
  output logic                  mem2dc_done0,
  output logic [DATA_W-1:0]     mem2dc_data_in0,
  input  logic [ADDR_W-1:0]     mem2dc_paddr1,
  input  logic [DATA_W/8-1:0]   mem2dc_write1,
  input  logic                  mem2dc_valid1,
  input  logic [DATA_W-1:0]     mem2dc_data_out1,
  output logic                  mem2dc_done1,
  output logic [DATA_W-1:0]     mem2dc_data_in1,
  output logic                  mem_en,
  output logic [RAM_AW-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_byteen,
  output logic                  ram_wren,
  output logic [MMIO_BIT-1:0]   mmio_addr,
  output logic [DATA_W/8-1:0]   mmio_wren,
  input  logic [DATA_W-1:0]     ram_q,
  input  logic [DATA_W-1:0]     periph_q
);

  localparam int c_BE_W = DATA_W / 8;
`ifdef MCPU_MEM_ARB_RR_EN
  localparam bit c_RR_EN = 1'b1;
`else
  localparam bit c_RR_EN = 1'b0;
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_gnt;
  logic                r_last;
  logic                r_sel_mmio;
  logic [DATA_W-1:0]   r_data_in0;
  logic [DATA_W-1:0]   r_data_in1;

  logic                w_resp0;
  logic                w_resp1;
  logic                w_elig0;
  logic                w_elig1;
  logic                w_issue;
  logic                w_sel;
  logic                w_done0;
  logic                w_done1;
  logic [ADDR_W-1:0]   w_paddr;
  logic [c_BE_W-1:0]   w_byteen;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_rdata;

  always_comb begin
    w_state_nxt = ST_IDLE;
    // A port in its response cycle is excluded so one request never earns two dones.
    w_resp0 = (r_state == ST_RESP) && !r_gnt;
    w_resp1 = (r_state == ST_RESP) && r_gnt;
    w_elig0 = mem2dc_valid0 && !w_resp0;
    w_elig1 = mem2dc_valid1 && !w_resp1;
    w_issue = clkrst_core_rst_n && (w_elig0 || w_elig1);
    w_sel   = (w_elig0 && w_elig1) ? (c_RR_EN && !r_last) : w_elig1;
    if (w_issue) begin
      w_state_nxt = ST_RESP;
    end
    w_done0  = clkrst_core_rst_n && w_resp0;
    w_done1  = clkrst_core_rst_n && w_resp1;
    w_paddr  = w_sel ? mem2dc_paddr1    : mem2dc_paddr0;
    w_byteen = w_sel ? mem2dc_write1    : mem2dc_write0;
    w_wdata  = w_sel ? mem2dc_data_out1 : mem2dc_data_out0;
    w_rdata  = r_sel_mmio ? periph_q : ram_q;
  end

  always_ff @(posedge clkrst_core_clk) begin
    if (!clkrst_core_rst_n) begin
      r_state    <= ST_IDLE;
      r_gnt      <= 1'b0;
      r_last     <= 1'b1;
      r_sel_mmio <= 1'b0;
      r_data_in0 <= '0;
      r_data_in1 <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_gnt      <= w_sel;
        r_last     <= w_sel;
        r_sel_mmio <= w_paddr[MMIO_BIT];
      end
      if (w_done0) begin
        r_data_in0 <= w_rdata;
      end
      if (w_done1) begin
        r_data_in1 <= w_rdata;
      end
    end
  end

  assign mem2dc_done0    = w_done0;
  assign mem2dc_done1    = w_done1;
  assign mem2dc_data_in0 = w_done0 ? w_rdata : r_data_in0;
  assign mem2dc_data_in1 = w_done1 ? w_rdata : r_data_in1;

  assign mem_en     = w_issue;
  assign mem_addr   = w_paddr[RAM_AW-1:0];
  assign mem_wdata  = w_wdata;
  assign mem_byteen = w_byteen;
  assign ram_wren   = w_issue && (|w_byteen) && !w_paddr[MMIO_BIT];
  assign mmio_addr  = w_paddr[MMIO_BIT-1:0];
  assign mmio_wren  = w_byteen & {c_BE_W{w_issue && w_paddr[MMIO_BIT]}};

endmodule
`default_nettype wire

// File: tb/tb_mcpu_mem_arb.sv
`default_nettype none
//==============================================================================
// Module  : tb_mcpu_mem_arb
// Brief   : Cycle-table vectors plus a two-port request scoreboard for mcpu_mem_arb.
// Rev     : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
module tb_mcpu_mem_arb;

`ifdef MCPU_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] paddr0, paddr1;
  logic [3:0]  write0, write1;
  logic        valid0, valid1;
  logic [31:0] dout0, dout1;
  logic        done0, done1;
  logic [31:0] din0, din1;
  logic        mem_en;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic        ram_wren;
  logic [28:0] mmio_addr;
  logic [3:0]  mmio_wren;
  logic [31:0] ram_q, periph_q;
  logic [31:0] tbl_ram_q, tbl_per_q;
  logic [31:0] mdl_ram_q = '0, mdl_per_q = '0, nxt_ram_q = '0, nxt_per_q = '0;
  logic        use_model;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign ram_q    = use_model ? mdl_ram_q : tbl_ram_q;
  assign periph_q = use_model ? mdl_per_q : tbl_per_q;

  mcpu_mem_arb dut (
    .clkrst_core_clk   (clk),
    .clkrst_core_rst_n (rst_n),
    .mem2dc_paddr0     (paddr0),
    .mem2dc_write0     (write0),
    .mem2dc_valid0     (valid0),
    .mem2dc_data_out0  (dout0),
    .mem2dc_done0      (done0),
    .mem2dc_data_in0   (din0),
    .mem2dc_paddr1     (paddr1),
    .mem2dc_write1     (write1),
    .mem2dc_valid1     (valid1),
    .mem2dc_data_out1  (dout1),
    .mem2dc_done1      (done1),
    .mem2dc_data_in1   (din1),
    .mem_en            (mem_en),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_byteen        (mem_byteen),
    .ram_wren          (ram_wren),
    .mmio_addr         (mmio_addr),
    .mmio_wren         (mmio_wren),
    .ram_q             (ram_q),
    .periph_q          (periph_q)
  );

  // Address-derived contents so returned data also proves the routing and address.
  function automatic logic [31:0] f_ram(input logic [13:0] a);
    return 32'hA500_0000 | {18'd0, a};
  endfunction
  function automatic logic [31:0] f_per(input logic [28:0] a);
    return 32'h5A00_0000 ^ {3'd0, a};
  endfunction

  // Memory/peripheral model: sample the strobe mid-cycle, present data next cycle.
  always @(negedge clk) begin
    if (mem_en) begin
      nxt_ram_q <= f_ram(mem_addr);
      nxt_per_q <= f_per(mmio_addr);
    end
  end
  always @(posedge clk) begin
    mdl_ram_q <= nxt_ram_q;
    mdl_per_q <= nxt_per_q;
  end

  typedef struct {
    bit          rst;
    bit          v0, v1;
    logic [3:0]  w0, w1;
    logic [29:0] a0, a1;
    logic [31:0] d0, d1, rq, pq;
    bit          en, dn0, dn1;
    logic [31:0] di0, di1;
    bit          rwr;
    logic [3:0]  mwr;
    logic [13:0] addr;
    logic [31:0] wd;
  } vec_t;

  function automatic vec_t mk(input bit rst, input bit v0, input bit v1,
                              input logic [3:0] w0, input logic [3:0] w1,
                              input logic [29:0] a0, input logic [29:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] rq, input logic [31:0] pq,
                              input bit en, input bit dn0, input bit dn1,
                              input logic [31:0] di0, input logic [31:0] di1,
                              input bit rwr, input logic [3:0] mwr,
                              input logic [13:0] addr, input logic [31:0] wd);
    vec_t t;
    t.rst = rst; t.v0 = v0; t.v1 = v1; t.w0 = w0; t.w1 = w1;
    t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1; t.rq = rq; t.pq = pq;
    t.en = en; t.dn0 = dn0; t.dn1 = dn1; t.di0 = di0; t.di1 = di1;
    t.rwr = rwr; t.mwr = mwr; t.addr = addr; t.wd = wd;
    return t;
  endfunction

  vec_t        tv[$];
  logic [31:0] q0[$], q1[$];
  logic        sb_v[2], sb_got[2];
  int          sb_wait[2];
  logic [29:0] sb_a[2];

  initial begin
    logic [29:0] a;
    logic [31:0] e, dv;
    logic        dn, ok;
    vec_t        t;

    use_model = 1'b0;
    rst_n = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
    paddr0 = '0; paddr1 = '0; write0 = '0; write1 = '0; dout0 = '0; dout1 = '0;
    tbl_ram_q = '0; tbl_per_q = '0;

    // One row per clock: inputs for that cycle, then outputs expected in that cycle.
    //                 rst v0 v1 w0 w1 a0           a1           d0        d1    rq            pq       en dn0 dn1 di0           di1      rwr mwr addr     wd
    tv.push_back(mk(0, 0, 0, 0, 0, 0,           0,           0,        0,    0,            0,       0, 0, 0, 0,            0,       0, 0, 0,       0));
    tv.push_back(mk(0, 1, 0, 0, 0, 'h10,        0,           0,        0,    0,            0,       0, 0, 0, 0,            0,       0, 0, 0,       0));
    tv.push_back(mk(1, 1, 0, 0, 0, 'h10,        0,           0,        0,    0,            0,       1, 0, 0, 0,            0,       0, 0, 'h10,    0));
    tv.push_back(mk(1, 1, 0, 0, 0, 'h10,        0,           0,        0,    32'hDEADBEEF, 0,       0, 1, 0, 32'hDEADBEEF, 0,       0, 0, 0,       0));
    tv.push_back(mk(1, 0, 0, 0, 0, 'h10,        0,           0,        0,    0,            0,       0, 0, 0, 32'hDEADBEEF, 0,       0, 0, 0,       0));
    tv.push_back(mk(1, 0, 1, 0, 4'hF, 0,        'h20000004,  0,        'h55, 0,            0,       1, 0, 0, 32'hDEADBEEF, 0,       0, 4'hF, 'h4,  'h55));
    tv.push_back(mk(1, 0, 1, 0, 4'hF, 0,        'h20000004,  0,        'h55, 0,            'h77,    0, 0, 1, 32'hDEADBEEF, 'h77,    0, 0, 0,       0));
    tv.push_back(mk(1, 0, 0, 0, 0, 0,           0,           0,        0,    0,            0,       0, 0, 0, 32'hDEADBEEF, 'h77,    0, 0, 0,       0));
    tv.push_back(mk(1, 1, 0, 0, 0, 'h20000000,  0,           0,        0,    0,            0,       1, 0, 0, 32'hDEADBEEF, 'h77,    0, 0, 0,       0));
    tv.push_back(mk(1, 1, 0, 0, 0, 'h20000000,  0,           0,        0,    'h9999,       'h1234,  0, 1, 0, 'h1234,       'h77,    0, 0, 0,       0));
    tv.push_back(mk(1, 0, 0, 0, 0, 0,           0,           0,        0,    0,            0,       0, 0, 0, 'h1234,       'h77,    0, 0, 0,       0));
    tv.push_back(mk(1, 1, 0, 4'h3, 0, 'h4008,   0,           'hCAFE,   0,    0,            0,       1, 0, 0, 'h1234,       'h77,    1, 0, 'h8,     'hCAFE));
    tv.push_back(mk(1, 1, 0, 4'h3, 0, 'h4008,   0,           'hCAFE,   0,    'hAAAA,       'hBBBB,  0, 1, 0, 'hAAAA,       'h77,    0, 0, 0,       0));
    tv.push_back(mk(1, 0, 0, 0, 0, 0,           0,           0,        0,    0,            0,       0, 0, 0, 'hAAAA,       'h77,    0, 0, 0,       0));
    tv.push_back(mk(0, 1, 1, 0, 0, 'h40,        'h80,        0,        0,    0,            0,       0, 0, 0, 'hAAAA,       'h77,    0, 0, 0,       0));
    tv.push_back(mk(0, 1, 1, 0, 0, 'h40,        'h80,        0,        0,    0,            0,       0, 0, 0, 0,            0,       0, 0, 0,       0));
    tv.push_back(mk(1, 1, 1, 0, 0, 'h40,        'h80,        0,        0,    0,            0,       1, 0, 0, 0,            0,       0, 0, 'h40,    0));
    tv.push_back(mk(1, 1, 1, 0, 0, 'h40,        'h80,        0,        0,    'h1111,       0,       1, 1, 0, 'h1111,       0,       0, 0, 'h80,    0));
    tv.push_back(mk(1, 0, 1, 0, 0, 'h40,        'h80,        0,        0,    'h2222,       0,       0, 0, 1, 'h1111,       'h2222,  0, 0, 0,       0));
    tv.push_back(mk(1, 0, 0, 0, 0, 0,           0,           0,        0,    0,            0,       0, 0, 0, 'h1111,       'h2222,  0, 0, 0,       0));
    tv.push_back(mk(1, 1, 0, 0, 0, 'h30,        0,           0,        0,    0,            0,       1, 0, 0, 'h1111,       'h2222,  0, 0, 'h30,    0));
    tv.push_back(mk(0, 1, 0, 0, 0, 'h30,        0,           0,        0,    'h3333,       0,       0, 0, 0, 'h1111,       'h2222,  0, 0, 0,       0));
    tv.push_back(mk(1, 0, 0, 0, 0, 0,           0,           0,        0,    0,            0,       0, 0, 0, 0,            0,       0, 0, 0,       0));
    tv.push_back(mk(1, 1, 0, 0, 0, 'h50,        0,           0,        0,    0,            0,       1, 0, 0, 0,            0,       0, 0, 'h50,    0));
    tv.push_back(mk(1, 1, 0, 0, 0, 'h50,        0,           0,        0,    'h4444,       0,       0, 1, 0, 'h4444,       0,       0, 0, 0,       0));
    tv.push_back(mk(1, 1, 1, 0, 0, 'h60,        'h70,        0,        0,    0,            0,       1, 0, 0, 'h4444,       0,       0, 0, RR ? 14'h70 : 14'h60, 0));
    tv.push_back(mk(1, 1, 1, 0, 0, 'h60,        'h70,        0,        0,    'h5555,       0,       1, !RR, RR,
                    RR ? 32'h4444 : 32'h5555, RR ? 32'h5555 : 32'h0, 0, 0, RR ? 14'h60 : 14'h70, 0));
    tv.push_back(mk(1, RR, !RR, 0, 0, 'h60,     'h70,        0,        0,    'h6666,       0,       0, RR, !RR,
                    RR ? 32'h6666 : 32'h5555, RR ? 32'h5555 : 32'h6666, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 0, 0,           0,           0,        0,    0,            0,       0, 0, 0,
                    RR ? 32'h6666 : 32'h5555, RR ? 32'h5555 : 32'h6666, 0, 0, 0, 0));

    repeat (2) @(posedge clk);

    for (int i = 0; i < tv.size(); i++) begin
      t = tv[i];
      @(posedge clk); #1;
      rst_n = t.rst; valid0 = t.v0; valid1 = t.v1; write0 = t.w0; write1 = t.w1;
      paddr0 = t.a0; paddr1 = t.a1; dout0 = t.d0; dout1 = t.d1;
      tbl_ram_q = t.rq; tbl_per_q = t.pq;
      #3;
      ok = (mem_en === t.en) && (done0 === t.dn0) && (done1 === t.dn1) &&
           (din0 === t.di0) && (din1 === t.di1) && (ram_wren === t.rwr) && (mmio_wren === t.mwr);
      if (t.en) ok = ok && (mem_addr === t.addr) && (mem_wdata === t.wd);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL vec%0d: got en=%b d0=%b d1=%b di0=%h di1=%h rw=%b mw=%h ad=%h wd=%h; want en=%b d0=%b d1=%b di0=%h di1=%h rw=%b mw=%h ad=%h wd=%h",
                    i, mem_en, done0, done1, din0, din1, ram_wren, mmio_wren, mem_addr, mem_wdata,
                    t.en, t.dn0, t.dn1, t.di0, t.di1, t.rwr, t.mwr, t.addr, t.wd);
    end

    // Scoreboard traffic: port 0 requests back-to-back, port 1 at random.
    use_model = 1'b1;
    rst_n = 1'b1; write0 = '0; write1 = '0; dout0 = '0; dout1 = '0;
    for (int p = 0; p < 2; p++) begin
      sb_v[p] = 1'b0; sb_got[p] = 1'b0; sb_wait[p] = 0; sb_a[p] = '0;
    end
    for (int cyc = 0; cyc < 90; cyc++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (sb_got[p]) begin
          sb_v[p] = 1'b0; sb_got[p] = 1'b0;
        end
        if (!sb_v[p] && cyc < 70 && (p == 0 || $urandom_range(1, 0) == 1)) begin
          a = {1'($urandom_range(1, 0)), 5'd0, 10'($urandom), 14'($urandom)};
          sb_a[p] = a; sb_v[p] = 1'b1; sb_wait[p] = 0;
          e = a[29] ? f_per(a[28:0]) : f_ram(a[13:0]);
          if (p == 0) q0.push_back(e);
          else        q1.push_back(e);
        end
      end
      valid0 = sb_v[0]; paddr0 = sb_a[0];
      valid1 = sb_v[1]; paddr1 = sb_a[1];
      #3;
      for (int p = 0; p < 2; p++) begin
        dn = (p == 0) ? done0 : done1;
        dv = (p == 0) ? din0  : din1;
        if (dn === 1'b1) begin
          n_total++;
          if (!sb_v[p] || ((p == 0) ? q0.size() : q1.size()) == 0) begin
            $display("FAIL sb_spurious_done%0d: got done=1 data=%h, want no done", p, dv);
          end else begin
            e = (p == 0) ? q0.pop_front() : q1.pop_front();
            if (dv === e) n_pass++;
            else $display("FAIL sb_rdata%0d cyc%0d: got %h, want %h", p, cyc, dv, e);
            sb_got[p] = 1'b1;
          end
        end else if (sb_v[p]) begin
          sb_wait[p]++;
          if (sb_wait[p] > 2) begin
            n_total++;
            $display("FAIL sb_latency%0d cyc%0d: got no done after %0d cycles, want <= 2", p, cyc, sb_wait[p]);
            if (p == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            sb_v[p] = 1'b0;
          end
        end
      end
    end

    n_total++;
    if (q0.size() == 0 && q1.size() == 0) n_pass++;
    else $display("FAIL sb_drain: got %0d/%0d outstanding, want 0/0", q0.size(), q1.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
